instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream fetch stage feeding the controller/decoder. It holds the program counter and issues word fetches to instruction memory over a req/ack handshake. It latches the returned instruction and presents it, with the decoded fields Cond/Op/Funct/Rd, until the datapath signals completion via Advance. The next PC is then computed from the controller's PCSrc and the ALU Result. A fetch watchdog flags a memory that never acknowledges.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width (fields below assume 32)
RESET_PC, 0, PC value after reset
TIMEOUT, 16, max REQ cycles without IMemAck before fault (>=1)

Ports:
Clock  in  1  single system clock, all state on rising edge
Reset  in  1  synchronous, active-high
PCSrc  in  1  from controller: 1 = take Result as next PC
Result  in  ADDR_W  branch/PC-write target from ALU/result mux
Advance  in  1  datapath done with current instruction; sampled only in HOLD
IMemReq  out  1  fetch request, high only in state REQ
IMemAddr  out  ADDR_W  fetch address, equals PC
IMemAck  in  1  memory has IMemRData valid this cycle
IMemRData  in  DATA_W  fetched instruction word
Instr  out  DATA_W  instruction register
InstrValid  out  1  Instr valid (state HOLD)
Cond  out  4  Instr[31:28]
Op  out  2  Instr[27:26]
Funct  out  6  Instr[25:20]
Rd  out  4  Instr[15:12]
PC  out  ADDR_W  current PC
PCPlus8  out  ADDR_W  PC+8 (R15 read value), modulo 2^ADDR_W
FetchFault  out  1  watchdog tripped; sticky until Reset

Behaviour:
- States: IDLE, REQ, HOLD, FAULT. Outputs are decoded from the registered state, with no combinational path from inputs to outputs.
- Reset (any state, including mid-fetch) applies at the edge:
  - state = IDLE, PC = RESET_PC with low 2 bits forced to 0.
  - Instr = 0, watchdog count = 0, FetchFault = 0.
  - An IMemAck arriving while Reset is high is ignored.
- IDLE: IMemReq = 0, InstrValid = 0. Goes to REQ unconditionally on the next edge.
- REQ: IMemReq = 1 and IMemAddr = PC, both stable until ack.
  - IMemAck = 1 at cycle n: Instr <= IMemRData at the end of cycle n, count cleared, state = HOLD at n+1. Ack in the first REQ cycle is legal, giving a minimum 1-cycle memory latency.
  - IMemAck = 0: count increments. When the count reaches TIMEOUT (TIMEOUT consecutive un-acked cycles), state = FAULT. An ack on the TIMEOUT-th cycle is a success.
- HOLD: InstrValid = 1, IMemReq = 0, and Instr plus all field outputs are held.
  - Advance = 0: stay in HOLD (stall, indefinitely).
  - Advance = 1: PC <= PCSrc ? {Result[ADDR_W-1:2], 2'b00} : PC+4. State = REQ at the next cycle.
- FAULT: IMemReq = 0, InstrValid = 0, FetchFault = 1. Exited only by Reset.
- Advance, PCSrc and Result are ignored outside HOLD. IMemAck is ignored outside REQ.
- Arithmetic: PC+4 and PC+8 wrap modulo 2^ADDR_W (0xFFFFFFFC+4 = 0x00000000). Result's low 2 bits are always discarded.
- Cond/Op/Funct/Rd are pure slices of the Instr register, so they read 0 after reset.
- Throughput: with a 1-cycle ack and Advance asserted in the first HOLD cycle, one instruction completes every 2 cycles.

Test Plan:
- Reset release, memory acks on the first REQ cycle with 0xE2811004 -> IMemReq high in cycle 2 with IMemAddr=0. Cycle 3: InstrValid=1, Cond=0xE, Op=0, Funct=0x28, Rd=1, PCPlus8=8.
- Sequential run: Advance=1, PCSrc=0 in HOLD, three times -> IMemAddr goes 0x0, 0x4, 0x8, 0xC on successive REQ states. Holding Advance=0 for 5 cycles keeps Instr unchanged and IMemReq=0.
- Branch: in HOLD, PCSrc=1, Result=0x00000103, Advance=1 -> next IMemAddr=0x00000100. PC=0xFFFFFFFC with PCSrc=0 -> next IMemAddr=0x00000000.
- Watchdog with TIMEOUT=16: ack withheld -> FetchFault=1 after 16 REQ cycles, and a later IMemAck is ignored. Ack on exactly the 16th cycle -> HOLD, no fault.
- Reset asserted during REQ with IMemAck=1 in the same cycle -> Instr stays 0, PC=RESET_PC, state IDLE. Reset during FAULT clears FetchFault.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// holds the instruction for the decoder until Advance, and flags a dead memory.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                TIMEOUT  = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              PCSrc,
   input  logic [ADDR_W-1:0] Result,
   input  logic              Advance,
   output logic              IMemReq,
   output logic [ADDR_W-1:0] IMemAddr,
   input  logic              IMemAck,
   input  logic [DATA_W-1:0] IMemRData,
   output logic [DATA_W-1:0] Instr,
   output logic              InstrValid,
   output logic [3:0]        Cond,
   output logic [1:0]        Op,
   output logic [5:0]        Funct,
   output logic [3:0]        Rd,
   output logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] PCPlus8,
   output logic              FetchFault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } state_t;

   // The counter only ever needs to hold TIMEOUT-1: the trip happens on the
   // cycle that would have taken it to TIMEOUT.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

   state_t            state;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] instr_q;
   logic [CNT_W-1:0]  wd_cnt;
   logic              req_q;
   logic              valid_q;
   logic              fault_q;
   logic [ADDR_W-1:0] branch_target;

   assign branch_target = {Result[ADDR_W-1:2], 2'b00};

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the values from before the edge, independent of order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         pc_q    <= RESET_PC_ALIGNED;
         instr_q <= '0;
         wd_cnt  <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               req_q <= 1'b1;
            end

            REQ: begin
               if (IMemAck) begin
                  instr_q <= IMemRData;
                  wd_cnt  <= '0;
                  state   <= HOLD;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end else if (wd_cnt == CNT_LAST) begin
                  state   <= FAULT;
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end

            HOLD: begin
               if (Advance) begin
                  pc_q    <= PCSrc ? branch_target : pc_q + ADDR_W'(4);
                  state   <= REQ;
                  req_q   <= 1'b1;
                  valid_q <= 1'b0;
               end
            end

            FAULT: begin
               // Sticky: only Reset leaves this state.
               state <= FAULT;
            end

            default: begin
               state   <= IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Word alignment discards the low bits of Result by design.
   logic unused_result_bits;
   assign unused_result_bits = ^Result[1:0];

   assign IMemReq    = req_q;
   assign IMemAddr   = pc_q;
   assign InstrValid = valid_q;
   assign FetchFault = fault_q;
   assign Instr      = instr_q;
   assign Cond       = instr_q[31:28];
   assign Op         = instr_q[27:26];
   assign Funct      = instr_q[25:20];
   assign Rd         = instr_q[15:12];
   assign PC         = pc_q;
   assign PCPlus8    = pc_q + ADDR_W'(8);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a transaction-level
// PC / instruction model.
module tb_instr_fetch_unit;

   localparam int TIMEOUT = 16;

   logic        Clock;
   logic        Reset;
   logic        PCSrc;
   logic [31:0] Result;
   logic        Advance;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemRData;
   logic [31:0] Instr;
   logic        InstrValid;
   logic [3:0]  Cond;
   logic [1:0]  Op;
   logic [5:0]  Funct;
   logic [3:0]  Rd;
   logic [31:0] PC;
   logic [31:0] PCPlus8;
   logic        FetchFault;

   instr_fetch_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .RESET_PC(32'h0),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .PCSrc     (PCSrc),
      .Result    (Result),
      .Advance   (Advance),
      .IMemReq   (IMemReq),
      .IMemAddr  (IMemAddr),
      .IMemAck   (IMemAck),
      .IMemRData (IMemRData),
      .Instr     (Instr),
      .InstrValid(InstrValid),
      .Cond      (Cond),
      .Op        (Op),
      .Funct     (Funct),
      .Rd        (Rd),
      .PC        (PC),
      .PCPlus8   (PCPlus8),
      .FetchFault(FetchFault)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int fails  = 0;

   // Reference model: architectural PC and last accepted instruction word.
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_hold(input string tag);
      check({tag, "_valid"}, InstrValid, 1);
      check({tag, "_req"},   IMemReq, 0);
      check({tag, "_fault"}, FetchFault, 0);
      check({tag, "_instr"}, Instr, exp_instr);
      check({tag, "_cond"},  Cond,  exp_instr >> 28);
      check({tag, "_op"},    Op,    (exp_instr >> 26) % 4);
      check({tag, "_funct"}, Funct, (exp_instr >> 20) % 64);
      check({tag, "_rd"},    Rd,    (exp_instr >> 12) % 16);
      check({tag, "_pc"},    PC,    exp_pc);
      check({tag, "_pc8"},   PCPlus8, (64'(exp_pc) + 64'd8) % 64'h1_0000_0000);
   endtask

   // Wait (bounded) for a request, withhold ack for 'delay' cycles, then ack.
   task automatic fetch(input logic [31:0] data, input int delay, input int exp_wait);
      int waited = 0;
      while (IMemReq !== 1'b1 && waited < 4) begin
         tick();
         waited++;
      end
      if (exp_wait >= 0) check("req_latency", waited, exp_wait);
      check("req_seen", IMemReq, 1);
      check("fetch_addr", IMemAddr, exp_pc);
      for (int d = 0; d < delay; d++) begin
         IMemAck   = 1'b0;
         IMemRData = $urandom;
         tick();
         check("req_stable", IMemReq, 1);
         check("addr_stable", IMemAddr, exp_pc);
         check("no_fault_yet", FetchFault, 0);
      end
      IMemAck   = 1'b1;
      IMemRData = data;
      tick();
      IMemAck   = 1'b0;
      IMemRData = $urandom;
      exp_instr = data;
      check_hold("hold");
   endtask

   // Stall for 'stall' cycles with junk on ignored inputs, then advance.
   task automatic advance(input int stall, input logic pcsrc, input logic [31:0] result);
      for (int s = 0; s < stall; s++) begin
         Advance   = 1'b0;
         PCSrc     = 1'($urandom);
         Result    = $urandom;
         IMemAck   = 1'($urandom);
         IMemRData = $urandom;
         tick();
         check_hold("stall");
      end
      IMemAck = 1'b0;
      Advance = 1'b1;
      PCSrc   = pcsrc;
      Result  = result;
      tick();
      Advance = 1'b0;
      PCSrc   = 1'($urandom);
      Result  = $urandom;
      exp_pc  = pcsrc ? (result & 32'hFFFF_FFFC) : exp_pc + 32'd4;
      check("adv_req", IMemReq, 1);
      check("adv_valid", InstrValid, 0);
      check("adv_addr", IMemAddr, exp_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit exceeded");
   end

   initial begin
      Reset = 1'b1; PCSrc = 1'b0; Result = '0; Advance = 1'b0;
      IMemAck = 1'b0; IMemRData = '0;
      exp_pc = 32'h0; exp_instr = 32'h0;

      // Reset state.
      tick();
      tick();
      check("rst_req", IMemReq, 0);
      check("rst_valid", InstrValid, 0);
      check("rst_instr", Instr, 0);
      check("rst_cond", Cond, 0);
      check("rst_rd", Rd, 0);
      check("rst_pc", PC, 0);
      check("rst_fault", FetchFault, 0);
      Reset = 1'b0;

      // First fetch: request one cycle after reset release, ack immediately.
      fetch(32'hE281_1004, 0, 1);
      check("first_cond", Cond, 4'hE);
      check("first_op", Op, 2'h0);
      check("first_funct", Funct, 6'h28);
      check("first_rd", Rd, 4'h1);
      check("first_pc8", PCPlus8, 32'h8);

      // Sequential run with back-to-back throughput and a 5-cycle stall.
      advance(0, 1'b0, 32'h0);
      fetch($urandom, 0, 0);
      advance(5, 1'b0, 32'h0);
      fetch($urandom, 0, 0);
      advance(0, 1'b0, 32'h0);
      check("seq_addr_c", IMemAddr, 32'hC);
      fetch($urandom, 1, 0);

      // Branch with misaligned target, then wrap around the top of memory.
      advance(0, 1'b1, 32'h0000_0103);
      check("branch_addr", IMemAddr, 32'h100);
      fetch($urandom, 0, 0);
      advance(1, 1'b1, 32'hFFFF_FFFF);
      fetch($urandom, 2, 0);
      check("wrap_pc8", PCPlus8, 32'h4);
      advance(0, 1'b0, 32'h0);
      check("wrap_addr", IMemAddr, 32'h0);

      // Ack on the last allowed cycle is a success.
      fetch($urandom, TIMEOUT - 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 30; i++) begin
         advance($urandom_range(0, 3), 1'($urandom), $urandom);
         fetch($urandom, $urandom_range(0, TIMEOUT - 1), 0);
      end

      // Watchdog: withhold ack entirely.
      advance(0, 1'b0, 32'h0);
      for (int i = 0; i < TIMEOUT; i++) begin
         check("wd_req", IMemReq, 1);
         check("wd_nofault", FetchFault, 0);
         tick();
      end
      check("wd_fault", FetchFault, 1);
      check("wd_req_off", IMemReq, 0);
      check("wd_valid_off", InstrValid, 0);
      for (int i = 0; i < 3; i++) begin
         IMemAck = 1'b1; IMemRData = $urandom; Advance = 1'($urandom);
         tick();
         check("fault_sticky", FetchFault, 1);
         check("fault_instr", Instr, exp_instr);
         check("fault_valid", InstrValid, 0);
      end
      IMemAck = 1'b0; Advance = 1'b0;

      // Reset out of FAULT.
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      exp_pc = 32'h0; exp_instr = 32'h0;
      check("unfault", FetchFault, 0);
      check("unfault_pc", PC, 0);
      check("unfault_instr", Instr, 0);
      fetch($urandom, 0, 1);
      advance(0, 1'b0, 32'h0);

      // Reset mid-fetch wins over a coincident ack.
      Reset = 1'b1; IMemAck = 1'b1; IMemRData = 32'hDEAD_BEEF;
      tick();
      Reset = 1'b0; IMemAck = 1'b0;
      exp_pc = 32'h0; exp_instr = 32'h0;
      check("rstack_instr", Instr, 0);
      check("rstack_pc", PC, 0);
      check("rstack_req", IMemReq, 0);
      check("rstack_valid", InstrValid, 0);
      fetch($urandom, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
